// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory request/response bus between the memory-access stage and memory
//
// Purpose: groups the data-memory handshake so the stage and the memory
//          model/controller connect through one port.
// Signals:
//   mem_req   : request valid (stage -> memory)
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_wdata : lane-shifted store data
//   mem_wstrb : byte write strobes
//   mem_ready : memory completes the request this cycle (memory -> stage)
//   mem_rdata : read word, valid with mem_ready on reads
// Modports: master = memory-access stage, slave = memory side.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage with byte/half/word loads and stores
//
// Purpose: takes execute's address/result and load/store controls on a start
//          pulse, runs one data-memory transaction over a req/ready handshake,
//          extends load data and presents the write-back value, destination and
//          enable with a one-cycle done pulse. Non-memory instructions complete
//          one cycle after start.
// Parameters:
//   MEM_TIMEOUT : cycles mem_req may stay high without mem_ready before the
//                 access aborts with access_error (0 disables the timeout)
// Ports:
//   clk, rstn                 : clock, synchronous active-low reset
//   start                     : one-cycle pulse, samples all *_in inputs
//   mem_read_enabled_in       : load instruction
//   mem_write_enabled_in      : store instruction
//   funct3_in                 : 000 b, 001 h, 010 w, 100 bu, 101 hu
//   result_in                 : execute result / byte address
//   store_data_in             : rs2 value for stores
//   reg_write_enabled_in/dest : write-back controls from execute
//   mem                       : data-memory bus (master side)
//   busy                      : transaction in progress (through the done cycle)
//   done                      : one-cycle completion pulse
//   result, reg_write_enabled, reg_write_dest, access_error : write-back outputs,
//                               held from one done to the next
module mem_access #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               mem_read_enabled_in,
  input  logic               mem_write_enabled_in,
  input  logic [2:0]         funct3_in,
  input  logic [31:0]        result_in,
  input  logic [31:0]        store_data_in,
  input  logic               reg_write_enabled_in,
  input  logic [4:0]         reg_write_dest_in,
  mem_access_if.master       mem,
  output logic               busy,
  output logic               done,
  output logic [31:0]        result,
  output logic               reg_write_enabled,
  output logic [4:0]         reg_write_dest,
  output logic               access_error
);

  typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

  // Counter only has to reach MEM_TIMEOUT-1; the abort fires on the cycle it does.
  localparam int          CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [31:0] TMO_LAST = MEM_TIMEOUT - 1;

  state_t          state;
  logic [CW-1:0]   tmo_cnt;
  logic [2:0]      lat_funct3;
  logic [1:0]      lat_lane;
  logic            lat_store;
  logic            lat_we;
  logic [4:0]      lat_dest;
  logic [31:0]     lat_result;

  logic            f3_legal;
  logic            misaligned;
  logic            in_error;
  logic [3:0]      st_strb;
  logic [31:0]     st_data;
  logic            timeout_hit;

  // Classification and store lane steering of the inputs presented with start.
  always_comb begin
    f3_legal   = (funct3_in == 3'b000) || (funct3_in == 3'b001) || (funct3_in == 3'b010) ||
                 (funct3_in == 3'b100) || (funct3_in == 3'b101);
    misaligned = ((funct3_in[1:0] == 2'b01) && result_in[0]) ||
                 ((funct3_in[1:0] == 2'b10) && (result_in[1:0] != 2'b00));
    in_error   = (mem_read_enabled_in && mem_write_enabled_in) || !f3_legal || misaligned;
    case (funct3_in[1:0])
      2'b00: begin
        st_strb = 4'b0001 << result_in[1:0];
        st_data = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << result_in[1:0];
        st_data = {2{store_data_in[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = store_data_in;
      end
    endcase
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && ({{(32-CW){1'b0}}, tmo_cnt} == TMO_LAST);

  // Little-endian lane select followed by sign/zero extension.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state             <= IDLE;
      tmo_cnt           <= '0;
      lat_funct3        <= 3'd0;
      lat_lane          <= 2'd0;
      lat_store         <= 1'b0;
      lat_we            <= 1'b0;
      lat_dest          <= 5'd0;
      lat_result        <= 32'd0;
      mem.mem_req       <= 1'b0;
      mem.mem_we        <= 1'b0;
      mem.mem_addr      <= 32'd0;
      mem.mem_wdata     <= 32'd0;
      mem.mem_wstrb     <= 4'd0;
      busy              <= 1'b0;
      done              <= 1'b0;
      result            <= 32'd0;
      reg_write_enabled <= 1'b0;
      reg_write_dest    <= 5'd0;
      access_error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lat_funct3 <= funct3_in;
            lat_lane   <= result_in[1:0];
            lat_store  <= mem_write_enabled_in;
            lat_we     <= reg_write_enabled_in;
            lat_dest   <= reg_write_dest_in;
            lat_result <= result_in;
            busy       <= 1'b1;
            if (!mem_read_enabled_in && !mem_write_enabled_in) begin
              result            <= result_in;
              reg_write_enabled <= reg_write_enabled_in;
              reg_write_dest    <= reg_write_dest_in;
              access_error      <= 1'b0;
              done              <= 1'b1;
              state             <= FIN;
            end else if (in_error) begin
              result            <= result_in;
              reg_write_enabled <= 1'b0;
              reg_write_dest    <= reg_write_dest_in;
              access_error      <= 1'b1;
              done              <= 1'b1;
              state             <= FIN;
            end else begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= mem_write_enabled_in;
              mem.mem_addr  <= {result_in[31:2], 2'b00};
              mem.mem_wstrb <= mem_write_enabled_in ? st_strb : 4'b0000;
              mem.mem_wdata <= mem_write_enabled_in ? st_data : 32'd0;
              tmo_cnt       <= '0;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            mem.mem_req       <= 1'b0;
            result            <= lat_store ? lat_result
                                           : load_ext(lat_funct3, lat_lane, mem.mem_rdata);
            reg_write_enabled <= lat_store ? 1'b0 : lat_we;
            reg_write_dest    <= lat_dest;
            access_error      <= 1'b0;
            done              <= 1'b1;
            state             <= FIN;
          end else if (timeout_hit) begin
            mem.mem_req       <= 1'b0;
            result            <= lat_result;
            reg_write_enabled <= 1'b0;
            reg_write_dest    <= lat_dest;
            access_error      <= 1'b1;
            done              <= 1'b1;
            state             <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a reference model
module tb_mem_access;
  localparam int unsigned TMO = 255;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        mem_read_enabled_in;
  logic        mem_write_enabled_in;
  logic [2:0]  funct3_in;
  logic [31:0] result_in;
  logic [31:0] store_data_in;
  logic        reg_write_enabled_in;
  logic [4:0]  reg_write_dest_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        reg_write_enabled;
  logic [4:0]  reg_write_dest;
  logic        access_error;

  int checks = 0;
  int failures = 0;

  mem_access_if mif();

  mem_access #(.MEM_TIMEOUT(TMO)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .start                (start),
    .mem_read_enabled_in  (mem_read_enabled_in),
    .mem_write_enabled_in (mem_write_enabled_in),
    .funct3_in            (funct3_in),
    .result_in            (result_in),
    .store_data_in        (store_data_in),
    .reg_write_enabled_in (reg_write_enabled_in),
    .reg_write_dest_in    (reg_write_dest_in),
    .mem                  (mif),
    .busy                 (busy),
    .done                 (done),
    .result               (result),
    .reg_write_enabled    (reg_write_enabled),
    .reg_write_dest       (reg_write_dest),
    .access_error         (access_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference load: shift the addressed byte/half down to bit 0, then extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * lane);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'd0, v[7:0]};
      3'b101:  return {16'd0, v[15:0]};
      default: return word;
    endcase
  endfunction

  task automatic scramble_inputs();
    mem_read_enabled_in  = 1'($urandom);
    mem_write_enabled_in = 1'($urandom);
    funct3_in            = 3'($urandom);
    result_in            = $urandom;
    store_data_in        = $urandom;
    reg_write_enabled_in = 1'($urandom);
    reg_write_dest_in    = 5'($urandom);
  endtask

  // Entered and left on a negedge. stall = ready-low req cycles before ready.
  task automatic run(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] sd, input logic we,
                     input logic [4:0] dest, input int stall, input logic [31:0] word);
    bit          is_mem, err, tmo, f3_ok;
    int          sz, exp_reqs, exp_done_c;
    logic [1:0]  lane;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata, exp_result, first_addr, first_wdata;
    logic [3:0]  first_strb;
    logic        first_we, exp_we, exp_err;
    int          c, done_c, reqs, unstable, busy_bad;
    logic [31:0] got_result;
    logic        got_we, got_err;

    is_mem = rd | wr;
    lane   = addr[1:0];
    sz     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    f3_ok  = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
    err    = is_mem && ((rd && wr) || !f3_ok || (addr % sz != 0));
    tmo    = is_mem && !err && (stall >= int'(TMO));
    exp_strb = wr ? 4'(((1 << sz) - 1) << lane) : 4'b0000;
    for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
    if (!is_mem || err) begin
      exp_reqs = 0; exp_done_c = 1;
    end else if (tmo) begin
      exp_reqs = int'(TMO); exp_done_c = int'(TMO) + 1;
    end else begin
      exp_reqs = stall + 1; exp_done_c = stall + 2;
    end
    exp_err    = err | tmo;
    exp_we     = (!is_mem) ? we : (exp_err || wr) ? 1'b0 : we;
    exp_result = (!is_mem) ? addr : ref_load(f3, lane, word);

    mem_read_enabled_in  = rd;
    mem_write_enabled_in = wr;
    funct3_in            = f3;
    result_in            = addr;
    store_data_in        = sd;
    reg_write_enabled_in = we;
    reg_write_dest_in    = dest;
    start                = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();

    c = 1; done_c = -1; reqs = 0; unstable = 0; busy_bad = 0;
    first_addr = 0; first_wdata = 0; first_strb = 0; first_we = 0;
    while (c <= 600) begin
      if (mif.mem_req) begin
        if (reqs == 0) begin
          first_addr = mif.mem_addr; first_wdata = mif.mem_wdata;
          first_strb = mif.mem_wstrb; first_we = mif.mem_we;
          check({tag, ".addr"}, mif.mem_addr, {addr[31:2], 2'b00});
          check({tag, ".we"}, 32'(mif.mem_we), 32'(wr));
          check({tag, ".wstrb"}, 32'(mif.mem_wstrb), 32'(exp_strb));
          if (wr) check({tag, ".wdata"}, mif.mem_wdata, exp_wdata);
        end else if (mif.mem_addr !== first_addr || mif.mem_wdata !== first_wdata ||
                     mif.mem_wstrb !== first_strb || mif.mem_we !== first_we) begin
          unstable++;
        end
        reqs++;
      end
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
      if (mif.mem_req && (reqs - 1) == stall) begin
        mif.mem_ready = 1'b1; mif.mem_rdata = word;
      end else begin
        mif.mem_ready = 1'b0; mif.mem_rdata = $urandom;
      end
      start = ($urandom_range(0, 3) == 0);
      scramble_inputs();
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    mif.mem_ready = 1'b0;

    check({tag, ".done_latency"}, 32'(done_c), 32'(exp_done_c));
    check({tag, ".req_cycles"}, 32'(reqs), 32'(exp_reqs));
    check({tag, ".req_stable"}, 32'(unstable), 32'd0);
    check({tag, ".busy"}, 32'(busy_bad), 32'd0);
    check({tag, ".err"}, 32'(access_error), 32'(exp_err));
    check({tag, ".rwe"}, 32'(reg_write_enabled), 32'(exp_we));
    check({tag, ".dest"}, 32'(reg_write_dest), 32'(dest));
    if (!exp_err && !wr) check({tag, ".result"}, result, exp_result);
    got_result = result; got_we = reg_write_enabled; got_err = access_error;

    @(negedge clk);
    check({tag, ".done_once"}, 32'(done), 32'd0);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".hold"}, {got_result[29:0], got_we, got_err},
          {result[29:0], reg_write_enabled, access_error});
  endtask

  initial begin
    int          bad;
    logic [2:0]  f3;
    logic        rd, wr;
    logic [31:0] a;

    rstn = 1'b0;
    start = 1'b0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'd0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    check("rst.mem_req", 32'(mif.mem_req), 32'd0);
    check("rst.mem_we", 32'(mif.mem_we), 32'd0);
    check("rst.mem_addr", mif.mem_addr, 32'd0);
    check("rst.mem_wdata", mif.mem_wdata, 32'd0);
    check("rst.mem_wstrb", 32'(mif.mem_wstrb), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.rwe", 32'(reg_write_enabled), 32'd0);
    check("rst.dest", 32'(reg_write_dest), 32'd0);
    check("rst.err", 32'(access_error), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    run("alu", 0, 0, 3'b000, 32'h0000_1234, 32'h0, 1, 5'd5, 0, 32'h0);
    run("lb", 1, 0, 3'b000, 32'h0000_0103, 32'h0, 1, 5'd7, 0, 32'h80FF_0000);
    run("lhu", 1, 0, 3'b101, 32'h0000_0202, 32'h0, 1, 5'd9, 3, 32'hBEEF_0000);
    run("sb", 0, 1, 3'b000, 32'h0000_0302, 32'h0000_00AB, 1, 5'd3, 0, 32'h0);
    run("sh", 0, 1, 3'b001, 32'h0000_0312, 32'h1234_5678, 1, 5'd4, 1, 32'h0);
    run("sw_mis", 0, 1, 3'b010, 32'h0000_0401, 32'h5555_AAAA, 1, 5'd6, 0, 32'h0);
    run("lh_mis", 1, 0, 3'b001, 32'h0000_0411, 32'h0, 1, 5'd2, 0, 32'h0);
    run("both", 1, 1, 3'b010, 32'h0000_0420, 32'h0, 1, 5'd8, 0, 32'h0);
    run("bad_f3", 1, 0, 3'b011, 32'h0000_0430, 32'h0, 1, 5'd1, 0, 32'h0);
    run("timeout", 1, 0, 3'b010, 32'h0000_0440, 32'h0, 1, 5'd11, 1000, 32'h0);

    // Reset during a stalled lw: request drops and no done follows.
    mem_read_enabled_in = 1; mem_write_enabled_in = 0; funct3_in = 3'b010;
    result_in = 32'h0000_0500; reg_write_enabled_in = 1; reg_write_dest_in = 5'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.req_before", 32'(mif.mem_req), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst.req", 32'(mif.mem_req), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    rstn = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || mif.mem_req !== 1'b0) bad++;
    end
    check("midrst.quiet", 32'(bad), 32'd0);
    run("lw_after_rst", 1, 0, 3'b010, 32'h0000_0504, 32'h0, 1, 5'd13, 0, 32'hCAFE_F00D);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: begin rd = 0; wr = 0; end
        1: begin rd = 1; wr = 0; end
        2: begin rd = 0; wr = 1; end
        default: begin rd = ($urandom_range(0, 3) != 0); wr = !rd | ($urandom_range(0, 3) == 0); end
      endcase
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (rd && $urandom_range(0, 1) == 1 && f3 != 3'b010) f3[2] = 1'b1;
      a = $urandom;
      run($sformatf("rnd%0d", n), rd, wr, f3, a, $urandom, 1'($urandom), 5'($urandom),
          $urandom_range(0, 4), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
